// File: rtl/instruction_queue.sv
// FIFO of fetched instruction words between fetch and decode. The head entry is
// presented as a full word and split into opcode/operand fields. A flush empties the queue.
module instruction_queue #(
  parameter int INSTR_WIDTH  = 24,
  parameter int OPCODE_WIDTH = 8,
  parameter int DEPTH        = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [INSTR_WIDTH-1:0]          in,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INSTR_WIDTH-1:0]          instruction,
  output logic [OPCODE_WIDTH-1:0]         opcode,
  output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] operand,
  output logic [CNT_WIDTH-1:0]            count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a word moves on an edge where its valid and ready are both high.
  // in_ready depends only on count, so a full queue refuses a push even during a pop.
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   push;
  logic                   pop;

  assign in_ready  = (count != CNT_WIDTH'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in;
  end

  assign instruction = out_valid ? mem[rd_ptr] : '0;
  assign opcode      = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign operand     = instruction[INSTR_WIDTH-OPCODE_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: reset, fill/backpressure, pop under full,
// simultaneous push/pop across wrap, flush, and asynchronous reset mid-operation.
module tb_instruction_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [23:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] instruction;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  instruction_queue #(
    .INSTR_WIDTH(24), .OPCODE_WIDTH(8), .DEPTH(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in(in_word), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .opcode(opcode), .operand(operand),
    .count(count)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [23:0] w);
    in_valid = 1'b1;
    in_word  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [23:0] exp);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_head"}, 32'(instruction), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_instr", 32'(instruction), 32'd0);
    rst_n = 1'b1;

    // 1: single push, one-cycle latency
    push_word(24'd20);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_instr", 32'(instruction), 32'd20);
    check("t1_opcode", 32'(opcode), 32'd0);
    check("t1_operand", 32'(operand), 32'd20);
    check("t1_count", 32'(count), 32'd1);
    pop_check("t1_pop", 24'd20);
    check("t1_empty_valid", 32'(out_valid), 32'd0);
    check("t1_empty_instr", 32'(instruction), 32'd0);

    // 2: fill to DEPTH, then a 5th word is held off
    push_word(24'h0A0001);
    push_word(24'h0B0002);
    push_word(24'h0C0003);
    push_word(24'h0D0004);
    check("t2_count", 32'(count), 32'd4);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_head", 32'(instruction), 32'h0A0001);
    check("t2_opcode", 32'(opcode), 32'h0A);
    check("t2_operand", 32'(operand), 32'h0001);
    push_word(24'd30);
    check("t2_hold_count", 32'(count), 32'd4);
    check("t2_hold_head", 32'(instruction), 32'h0A0001);

    // 3: pop while full and in_valid high: no push that cycle
    in_valid = 1'b1; in_word = 24'd30; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_count_after_pop", 32'(count), 32'd3);
    check("t3_head_after_pop", 32'(instruction), 32'h0B0002);
    step();
    in_valid = 1'b0;
    check("t3_count_full", 32'(count), 32'd4);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    pop_check("t3_d0", 24'h0B0002);
    pop_check("t3_d1", 24'h0C0003);
    pop_check("t3_d2", 24'h0D0004);
    pop_check("t3_d3", 24'd30);
    check("t3_drained", 32'(count), 32'd0);

    // 4: simultaneous push and pop at count=2, write pointer wraps
    push_word(24'h110001);
    push_word(24'h220002);
    check("t4_count", 32'(count), 32'd2);
    in_valid = 1'b1; in_word = 24'h330003; out_ready = 1'b1;
    step();
    check("t4_pp1_count", 32'(count), 32'd2);
    check("t4_pp1_head", 32'(instruction), 32'h220002);
    in_word = 24'h440004;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t4_pp2_count", 32'(count), 32'd2);
    check("t4_pp2_head", 32'(instruction), 32'h330003);
    pop_check("t4_d0", 24'h330003);
    pop_check("t4_d1", 24'h440004);
    check("t4_drained", 32'(count), 32'd0);

    // 5: flush with a same-cycle push; the pushed word is dropped
    push_word(24'h000001);
    push_word(24'h000002);
    push_word(24'h000003);
    check("t5_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_word = 24'h000055;
    check("t5_in_ready_flush", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_instr", 32'(instruction), 32'd0);
    check("t5_opcode", 32'(opcode), 32'd0);
    check("t5_operand", 32'(operand), 32'd0);
    push_word(24'h000077);
    check("t5_next_count", 32'(count), 32'd1);
    pop_check("t5_next", 24'h000077);

    // 6: asynchronous reset between edges
    push_word(24'h000100);
    push_word(24'h000200);
    check("t6_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_instr", 32'(instruction), 32'd0);
    check("t6_async_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    push_word(24'd30);
    check("t6_instr", 32'(instruction), 32'd30);
    check("t6_count_after", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
